read_session_ctrl: RTL and testbench
====================================

// Module: read_session_ctrl
// PURPOSE
//  Consumes the debounced one-clock START pulse from the user button controller and runs one
//  AVC read session per pulse. Handshakes a request to the vector reader engine, counts the
//  vectors it streams, and latches done/error status for board LEDs and the host.
//  Sits directly downstream of the button debouncer, between the user buttons and the reader engine.
// PARAMETERS
//  CNT_W        16        width of vector counter vec_cnt
//  TIMEOUT_CYC  16'hFFFF  watchdog limit, clk cycles without reader activity (RSC_TIMEOUT_EN only)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      debounced START pulse, one clk wide
//  rd_req     out  1      read request to reader engine (registered)
//  rd_ack     in   1      reader engine accepts request
//  vec_valid  in   1      one vector transferred this cycle
//  vec_eof    in   1      last vector / end of file this cycle
//  rd_err     in   1      reader engine fault (media, format)
//  busy       out  1      session in progress (REQ or STREAM)
//  done       out  1      last session ended cleanly; sticky until next accepted start
//  err        out  1      last session failed; sticky until next accepted start
//  err_code   out  2      2'b01 reader fault, 2'b10 timeout, 2'b00 none
//  vec_cnt    out  CNT_W  vectors counted in current/last session
//  state      out  3      encoded FSM state for LED/debug
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE; rd_req, busy, done, err = 0; err_code=0; vec_cnt=0.
//    rd_req deasserts immediately, without waiting for a clock edge; session is abandoned, no status kept.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - States: IDLE=3'd0, REQ=3'd1, STREAM=3'd2, DONE=3'd3, ERROR=3'd4.
//  - IDLE/DONE/ERROR + start=1 -> REQ next cycle; same edge clears vec_cnt, done, err, err_code;
//    rd_req=1 and busy=1 from the first REQ cycle.
//  - start while in REQ or STREAM is ignored (no restart, no counter clear).
//  - REQ: rd_req held high until rd_ack sampled 1 -> STREAM; rd_req low from the first STREAM cycle.
//    vec_valid/vec_eof in REQ are ignored.
//  - STREAM: each cycle with vec_valid=1 increments vec_cnt by 1. Saturates at all-ones, no wrap.
//  - STREAM + vec_eof=1 -> DONE; a vec_valid in the same cycle is counted. DONE: done=1, busy=0.
//  - rd_err=1 in REQ or STREAM -> ERROR, err=1, err_code=2'b01, busy=0.
//    rd_err takes priority over vec_eof in the same cycle; vec_valid in that cycle is still counted.
//  - rd_err, vec_eof and vec_valid in IDLE/DONE/ERROR are ignored; vec_cnt holds its final value.
//  - done and err are never 1 together.
// CONFIGURATION
//  RSC_TIMEOUT_EN defined:
//   - wdog counter cleared on entry to REQ and on any cycle with rd_ack or vec_valid; otherwise +1 in REQ/STREAM.
//   - wdog == TIMEOUT_CYC-1 with no activity -> ERROR next cycle; err=1, err_code=2'b10; rd_req dropped.
//   - rd_err in the same cycle wins: err_code=2'b01.
//  RSC_TIMEOUT_EN undefined:
//   - no watchdog logic; REQ/STREAM wait indefinitely; err_code=2'b10 is never produced.
// TESTING
//  1 reset mid-STREAM with vec_cnt=5 -> next sample: state=0, rd_req=0, busy=0, vec_cnt=0, done=err=0.
//  2 start; rd_ack at REQ cycle 3; 10 vec_valid; vec_eof together with the 10th
//    -> vec_cnt=10, done=1, busy=0, state=3; rd_req high exactly 3 cycles.
//  3 in STREAM, rd_err and vec_eof together -> state=4, err=1, err_code=2'b01, done=0.
//  4 start pulses during REQ and STREAM -> ignored, vec_cnt unchanged;
//    start in DONE -> vec_cnt=0, done=0, state=1.
//  5 CNT_W=4: 20 vec_valid then vec_eof -> vec_cnt=4'hF, done=1.
//  6 RSC_TIMEOUT_EN, TIMEOUT_CYC=8: start, no rd_ack -> ERROR after 8 REQ cycles, err_code=2'b10;
//    without the macro: still REQ at cycle 100.

Source files
------------

// File: rtl/read_session_ctrl.sv
// AVC read-session controller: one reader-engine session per debounced START pulse.
// Optional watchdog enabled by defining RSC_TIMEOUT_EN.
module read_session_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             rd_req,
    input  logic             rd_ack,
    input  logic             vec_valid,
    input  logic             vec_eof,
    input  logic             rd_err,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [2:0]       state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ERROR  = 3'd4;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_READER  = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65536) begin : g_bad_timeout
        $error("read_session_ctrl: TIMEOUT_CYC out of range");
    end

    logic in_session;
    logic accept_start;
    logic tmo_hit;

    assign in_session   = (state == REQ) || (state == STREAM);
    assign accept_start = start && !in_session;

`ifdef RSC_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

    logic [15:0] wdog;

    assign tmo_hit = in_session && !rd_ack && !vec_valid && (wdog == WDOG_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog <= '0;
        end else if (accept_start || rd_ack || vec_valid) begin
            wdog <= '0;
        end else if (in_session) begin
            wdog <= wdog + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= CODE_NONE;
            vec_cnt  <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state    <= REQ;
                        rd_req   <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        err_code <= CODE_NONE;
                        vec_cnt  <= '0;
                    end
                end
                REQ: begin
                    if (rd_err || tmo_hit) begin
                        state    <= ERROR;
                        rd_req   <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= rd_err ? CODE_READER : CODE_TIMEOUT;
                    end else if (rd_ack) begin
                        state  <= STREAM;
                        rd_req <= 1'b0;
                    end
                end
                STREAM: begin
                    if (vec_valid && (vec_cnt != '1)) begin
                        vec_cnt <= vec_cnt + 1'b1;
                    end
                    // reader fault outranks end-of-file; a clean EOF outranks the watchdog
                    if (rd_err) begin
                        state    <= ERROR;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= CODE_READER;
                    end else if (vec_eof) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (tmo_hit) begin
                        state    <= ERROR;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= CODE_TIMEOUT;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rd_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_session_ctrl.sv
// Directed self-checking bench for read_session_ctrl (16-bit and 4-bit counter instances).
module tb_read_session_ctrl;

    logic clk = 1'b0;
    logic reset, start, rd_ack, vec_valid, vec_eof, rd_err;

    logic        rd_req, busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] vec_cnt;
    logic [2:0]  state;

    logic        rd_req4, busy4, done4, err4;
    logic [1:0]  err_code4;
    logic [3:0]  vec_cnt4;
    logic [2:0]  state4;

    int vectors = 0;
    int miscompares = 0;

    read_session_ctrl #(.CNT_W(16), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset), .start(start), .rd_req(rd_req), .rd_ack(rd_ack),
        .vec_valid(vec_valid), .vec_eof(vec_eof), .rd_err(rd_err), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .vec_cnt(vec_cnt), .state(state)
    );

    read_session_ctrl #(.CNT_W(4), .TIMEOUT_CYC(8)) dut4 (
        .clk(clk), .reset(reset), .start(start), .rd_req(rd_req4), .rd_ack(rd_ack),
        .vec_valid(vec_valid), .vec_eof(vec_eof), .rd_err(rd_err), .busy(busy4),
        .done(done4), .err(err4), .err_code(err_code4), .vec_cnt(vec_cnt4), .state(state4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0; rd_ack = 1'b0; vec_valid = 1'b0; vec_eof = 1'b0; rd_err = 1'b0;
        tick(); tick();
        reset = 1'b0;
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL por_state: got %0d want 0", state); end
        vectors++; if ({rd_req, busy, done, err} !== 4'b0000) begin miscompares++; $display("FAIL por_flags: got %b want 0000", {rd_req, busy, done, err}); end
        // async reset in REQ: rd_req must drop without a clock edge
        do_start();
        vectors++; if (rd_req !== 1'b1) begin miscompares++; $display("FAIL req_before_reset: got %b want 1", rd_req); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL async_rd_req: got %b want 0", rd_req); end
        tick();
        reset = 1'b0;
        // reset mid-STREAM with vec_cnt=5
        do_start();
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        vec_valid = 1'b1; repeat (5) tick(); vec_valid = 1'b0;
        vectors++; if (vec_cnt !== 16'd5 || state !== 3'd2) begin miscompares++; $display("FAIL pre_reset_stream: got cnt=%0d st=%0d want cnt=5 st=2", vec_cnt, state); end
        #2 reset = 1'b1;
        #1;
        vectors++; if (state !== 3'd0 || vec_cnt !== 16'd0) begin miscompares++; $display("FAIL async_reset_state: got st=%0d cnt=%0d want st=0 cnt=0", state, vec_cnt); end
        vectors++; if ({rd_req, busy, done, err, err_code} !== 6'b0) begin miscompares++; $display("FAIL async_reset_flags: got %b want 000000", {rd_req, busy, done, err, err_code}); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_session();
        int req_cycles = 0;
        do_start();
        vectors++; if (busy !== 1'b1 || state !== 3'd1) begin miscompares++; $display("FAIL req_entry: got busy=%b st=%0d want busy=1 st=1", busy, state); end
        if (rd_req) req_cycles++;
        tick(); if (rd_req) req_cycles++;
        tick(); if (rd_req) req_cycles++;
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        if (rd_req) req_cycles++;
        vectors++; if (state !== 3'd2 || busy !== 1'b1) begin miscompares++; $display("FAIL stream_entry: got st=%0d busy=%b want st=2 busy=1", state, busy); end
        for (int i = 1; i <= 10; i++) begin
            vec_valid = 1'b1;
            vec_eof = (i == 10);
            tick();
        end
        vec_valid = 1'b0; vec_eof = 1'b0;
        vectors++; if (req_cycles !== 3) begin miscompares++; $display("FAIL rd_req_len: got %0d want 3", req_cycles); end
        vectors++; if (vec_cnt !== 16'd10) begin miscompares++; $display("FAIL session_cnt: got %0d want 10", vec_cnt); end
        vectors++; if ({done, err, busy} !== 3'b100 || state !== 3'd3) begin miscompares++; $display("FAIL session_done: got d/e/b=%b st=%0d want 100 st=3", {done, err, busy}, state); end
        vec_valid = 1'b1; vec_eof = 1'b1; rd_err = 1'b1; tick();
        vec_valid = 1'b0; vec_eof = 1'b0; rd_err = 1'b0;
        vectors++; if (vec_cnt !== 16'd10 || state !== 3'd3 || err !== 1'b0) begin miscompares++; $display("FAIL done_ignores: got cnt=%0d st=%0d err=%b want 10/3/0", vec_cnt, state, err); end
    endtask

    task automatic test_error();
        do_start();
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        vec_valid = 1'b1; tick(); tick();
        rd_err = 1'b1; vec_eof = 1'b1; tick();
        rd_err = 1'b0; vec_eof = 1'b0; vec_valid = 1'b0;
        vectors++; if (state !== 3'd4 || err_code !== 2'b01) begin miscompares++; $display("FAIL err_state: got st=%0d code=%b want st=4 code=01", state, err_code); end
        vectors++; if ({err, done, busy} !== 3'b100) begin miscompares++; $display("FAIL err_flags: got e/d/b=%b want 100", {err, done, busy}); end
        vectors++; if (vec_cnt !== 16'd3) begin miscompares++; $display("FAIL err_cnt: got %0d want 3", vec_cnt); end
        vec_valid = 1'b1; tick(); vec_valid = 1'b0;
        vectors++; if (vec_cnt !== 16'd3 || state !== 3'd4) begin miscompares++; $display("FAIL err_hold: got cnt=%0d st=%0d want 3/4", vec_cnt, state); end
        // rd_err while still in REQ
        do_start();
        rd_err = 1'b1; tick(); rd_err = 1'b0;
        vectors++; if (state !== 3'd4 || rd_req !== 1'b0 || err_code !== 2'b01) begin miscompares++; $display("FAIL req_err: got st=%0d req=%b code=%b want 4/0/01", state, rd_req, err_code); end
    endtask

    task automatic test_ignore_start();
        do_start();
        vectors++; if (state !== 3'd1 || vec_cnt !== 16'd0 || err !== 1'b0 || err_code !== 2'b00) begin miscompares++; $display("FAIL restart_from_err: got st=%0d cnt=%0d err=%b code=%b want 1/0/0/00", state, vec_cnt, err, err_code); end
        vec_valid = 1'b1; start = 1'b1; tick(); start = 1'b0; vec_valid = 1'b0;
        vectors++; if (state !== 3'd1 || rd_req !== 1'b1 || vec_cnt !== 16'd0) begin miscompares++; $display("FAIL start_in_req: got st=%0d req=%b cnt=%0d want 1/1/0", state, rd_req, vec_cnt); end
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        vec_valid = 1'b1; repeat (4) tick(); vec_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        vectors++; if (state !== 3'd2 || vec_cnt !== 16'd4) begin miscompares++; $display("FAIL start_in_stream: got st=%0d cnt=%0d want 2/4", state, vec_cnt); end
        vec_eof = 1'b1; tick(); vec_eof = 1'b0;
        vectors++; if (state !== 3'd3 || vec_cnt !== 16'd4 || done !== 1'b1) begin miscompares++; $display("FAIL eof_no_valid: got st=%0d cnt=%0d done=%b want 3/4/1", state, vec_cnt, done); end
        do_start();
        vectors++; if (state !== 3'd1 || vec_cnt !== 16'd0 || done !== 1'b0) begin miscompares++; $display("FAIL start_in_done: got st=%0d cnt=%0d done=%b want 1/0/0", state, vec_cnt, done); end
    endtask

    task automatic test_saturate();
        rd_ack = 1'b1; tick(); rd_ack = 1'b0;
        vec_valid = 1'b1; repeat (15) tick();
        vectors++; if (vec_cnt4 !== 4'hF) begin miscompares++; $display("FAIL sat_reach: got %h want f", vec_cnt4); end
        repeat (5) tick();
        vec_valid = 1'b0; vec_eof = 1'b1; tick(); vec_eof = 1'b0;
        vectors++; if (vec_cnt4 !== 4'hF || done4 !== 1'b1) begin miscompares++; $display("FAIL sat_hold: got cnt=%h done=%b want f/1", vec_cnt4, done4); end
        vectors++; if (vec_cnt !== 16'd20) begin miscompares++; $display("FAIL wide_cnt: got %0d want 20", vec_cnt); end
    endtask

    task automatic test_timeout();
        do_start();
`ifdef RSC_TIMEOUT_EN
        repeat (7) tick();
        vectors++; if (state !== 3'd1 || rd_req !== 1'b1) begin miscompares++; $display("FAIL tmo_req8: got st=%0d req=%b want 1/1", state, rd_req); end
        tick();
        vectors++; if (state !== 3'd4 || err_code !== 2'b10 || rd_req !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL tmo_fire: got st=%0d code=%b req=%b err=%b want 4/10/0/1", state, err_code, rd_req, err); end
`else
        repeat (99) tick();
        vectors++; if (state !== 3'd1 || rd_req !== 1'b1 || err !== 1'b0 || err_code !== 2'b00) begin miscompares++; $display("FAIL no_tmo_req100: got st=%0d req=%b err=%b code=%b want 1/1/0/00", state, rd_req, err, err_code); end
`endif
    endtask

    initial begin
        test_reset();
        test_session();
        test_error();
        test_ignore_start();
        test_saturate();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
